// File: rtl/fastica_pkg.sv
// rtl/fastica_pkg.sv - shared FastICA fixed-point constants and convergence-check state type
package fastica_pkg;

    localparam int DATA_W  = 26;
    localparam int FRAC_W  = 13;
    localparam int Q13_ONE = 8192;
    localparam int TOL_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/abs_sat.sv
// rtl/abs_sat.sv - signed to saturated unsigned magnitude, most-negative input clamps to max positive
module abs_sat #(
    parameter int W = 26
) (
    input  logic signed [W-1:0] din,
    output logic        [W-1:0] mag
);

    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0] din_u;

    assign din_u = din;

    always_comb begin
        mag = din_u;
        if (din_u == MIN_V) begin
            mag = MAX_V;
        end else if (din_u[W-1]) begin
            mag = ~din_u + 1'b1;
        end
    end

endmodule

// File: rtl/error_converge_check.sv
// rtl/error_converge_check.sv - serial max/sum scan of the 4x4 error matrix with convergence verdict
module error_converge_check
    import fastica_pkg::*;
#(
    parameter int W        = DATA_W,
    parameter int TOL      = TOL_DEF,
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic                clk_conv,
    input  logic                rst_conv,
    input  logic                en_conv,
    input  logic                clr_iter,
    input  logic signed [W-1:0] i11,
    input  logic signed [W-1:0] i12,
    input  logic signed [W-1:0] i13,
    input  logic signed [W-1:0] i14,
    input  logic signed [W-1:0] i21,
    input  logic signed [W-1:0] i22,
    input  logic signed [W-1:0] i23,
    input  logic signed [W-1:0] i24,
    input  logic signed [W-1:0] i31,
    input  logic signed [W-1:0] i32,
    input  logic signed [W-1:0] i33,
    input  logic signed [W-1:0] i34,
    input  logic signed [W-1:0] i41,
    input  logic signed [W-1:0] i42,
    input  logic signed [W-1:0] i43,
    input  logic signed [W-1:0] i44,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic                timeout,
    output logic [W-1:0]        max_err,
    output logic [W+3:0]        sum_err,
    output logic [ITER_W-1:0]   iter_cnt
);

    conv_state_t state, state_nxt;

    logic [W-1:0]        elems [16];
    logic [W-1:0]        cap   [16];
    logic signed [W-1:0] elem;
    logic [W-1:0]        mag;
    logic [W-1:0]        mx;
    logic [W+3:0]        sm;
    logic [3:0]          idx;
    logic                run_conv;
    logic [ITER_W-1:0]   iter_inc;

    assign elems = '{i11, i12, i13, i14, i21, i22, i23, i24,
                     i31, i32, i33, i34, i41, i42, i43, i44};

    assign elem     = cap[idx];
    assign run_conv = (mx < W'(TOL));
    assign iter_inc = (&iter_cnt) ? iter_cnt : iter_cnt + 1'b1;

    abs_sat #(.W(W)) u_abs_sat (
        .din (elem),
        .mag (mag)
    );

    always_ff @(posedge clk_conv) begin
        if (rst_conv) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_conv) state_nxt = SCAN;
            SCAN:    if (idx == 4'd15) state_nxt = DECIDE;
            DECIDE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Capture bank is deliberately unreset; it is only read after a fresh capture.
    always_ff @(posedge clk_conv) begin
        if (state == IDLE && en_conv) begin
            for (int k = 0; k < 16; k++) begin
                cap[k] <= elems[k];
            end
        end
    end

    always_ff @(posedge clk_conv) begin
        if (rst_conv) begin
            idx       <= '0;
            mx        <= '0;
            sm        <= '0;
            done      <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            max_err   <= '0;
            sum_err   <= '0;
            iter_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_conv) begin
                        idx <= '0;
                        mx  <= '0;
                        sm  <= '0;
                    end
                end
                SCAN: begin
                    if (mag > mx) mx <= mag;
                    sm  <= sm + {4'b0000, mag};
                    idx <= idx + 1'b1;
                end
                DECIDE: begin
                    max_err   <= mx;
                    sum_err   <= sm;
                    converged <= run_conv;
                    done      <= 1'b1;
                    iter_cnt  <= iter_inc;
                    if (!run_conv && iter_inc == ITER_W'(MAX_ITER)) timeout <= 1'b1;
                end
                default: ;
            endcase
            // Clear takes priority over a coincident DECIDE update.
            if (clr_iter) begin
                iter_cnt <= '0;
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/error_converge_check.md
Name: error_converge_check

Overview:
- Consumer of the 4x4 Q13 absolute-error matrix produced by the error-magnitude stage of the FastICA update loop.
- On a start pulse it captures all 16 elements and scans them serially, one per cycle, accumulating the max and the sum.
- It then compares the max against a tolerance and reports converged or not-converged, counts iterations, and flags a timeout.
- The FastICA controller uses its verdict to stop iterating or to loop again.

Parameters:
- W, 26, data width (signed Q12.13 fixed point)
- TOL, 8, convergence tolerance in Q13 LSBs (about 0.001); compared unsigned
- MAX_ITER, 255, iteration limit before timeout
- ITER_W, 8, iteration counter width; must satisfy MAX_ITER < 2^ITER_W

Ports:
- clk_conv  input  1  single clock, rising edge
- rst_conv  input  1  synchronous, active-high reset
- en_conv  input  1  start pulse; sampled only in IDLE
- clr_iter  input  1  synchronous clear of the iteration counter and timeout
- i11..i44  input  W each (16 ports)  error matrix elements, signed
- busy  output  1  high while a scan/decide is in progress
- done  output  1  one-cycle pulse when the verdict is valid
- converged  output  1  max_err < TOL for the last completed run
- timeout  output  1  sticky; set when iter_cnt reaches MAX_ITER without convergence
- max_err  output  W  largest element magnitude, unsigned, MSB always 0
- sum_err  output  W+4  sum of the 16 magnitudes, unsigned
- iter_cnt  output  ITER_W  completed runs since reset or clr_iter

Behaviour:
- Reset (rst_conv=1 at an edge): state IDLE; busy, done, converged and timeout = 0; max_err, sum_err, iter_cnt = 0; capture registers are don't-care. Reset overrides everything, including mid-scan; the run is aborted with no done pulse.
- States: IDLE, SCAN, DECIDE.
- IDLE:
  - On en_conv=1, register all 16 inputs, clear the running max/sum, set idx=0, go to SCAN, busy=1.
  - Previous verdict outputs hold until the next DECIDE.
- SCAN:
  - Each edge processes element idx in row-major order (i11, i12 … i44): m = |elem|, mx = max(mx, m), sm += m, idx++.
  - After idx=15 is processed (16 edges), go to DECIDE.
  - en_conv is ignored while busy.
- DECIDE (1 edge):
  - max_err <= mx, sum_err <= sm, converged <= (mx < TOL), done <= 1 for exactly one cycle, busy <= 0, go to IDLE.
  - iter_cnt increments, saturating at 2^ITER_W-1.
  - timeout <= 1 if the not-converged run makes iter_cnt reach MAX_ITER.
- Latency: with the start sampled at edge 0, done is high after edge 17 for one cycle. Back-to-back: a new en_conv is accepted on the first IDLE cycle, so the minimum start-to-start period is 18 cycles.
- Magnitude rule:
  - Inputs are nominally non-negative, but negatives are tolerated and negated.
  - The most-negative value -2^(W-1) saturates to 2^(W-1)-1.
- Sum width W+4 cannot overflow (16 x max < 2^(W+3)).
- clr_iter: iter_cnt <= 0 and timeout <= 0. If clr_iter coincides with DECIDE, clear wins; verdict outputs still update and done still pulses.
- converged is not sticky; it reflects only the last run. timeout stays high until clr_iter or reset.

Decomposition:
- Shared package fastica_pkg holds: W=26, FRAC=13, Q13 ONE=8192, a default TOL constant, and a state enum {IDLE, SCAN, DECIDE}.
- One combinational sub-module, abs_sat (W-bit signed in, W-bit saturated magnitude out), is instantiated once and driven by the idx mux. It is reusable by other FastICA stages.

Test Plan:
1. All inputs 0, en_conv pulse -> done 17 cycles after start; converged=1, max_err=0, sum_err=0, iter_cnt=1.
2. i23=100, others 0 -> max_err=100, sum_err=100, converged=0; i44=100 as the last element is also captured.
3. i11=-50, i42=30 -> max_err=50, sum_err=80; i11=-2^25 -> max_err=33554431.
4. All 16 elements = 8 (=TOL) -> converged=0 (strict compare), sum_err=128; all = 7 -> converged=1, sum_err=112.
5. MAX_ITER=3, three runs with i11=1000 -> timeout=1 after the third done, iter_cnt=3; then clr_iter -> timeout=0, iter_cnt=0; clr_iter coincident with DECIDE -> iter_cnt=0.
6. en_conv again at scan cycle 5 -> ignored, one done only; rst_conv at scan cycle 8 -> no done, all outputs 0; the next start completes normally.
